// File: rtl/diff_core_pkg.sv
// rtl/diff_core_pkg.sv - shared widths, iteration counts and FSM state type for the sequential divider
package diff_core_pkg;

    localparam int LANE_W = 8;
    localparam int SUB_W  = 4;
    localparam int DVD_W  = 2 * LANE_W;
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] ITER_FULL = 4'd8;
    localparam logic [CNT_W-1:0] ITER_DUAL = 4'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring divide step for a W-bit lane
module div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0]   part;
    logic [W-1:0] diff;

    // The shifted partial remainder needs W+1 bits; when the subtract is taken
    // the true difference is below div_i, so the low W bits of a modular W-bit
    // subtract are exact.
    assign part  = {rem_i, bit_i};
    assign q_o   = (part >= {1'b0, div_i});
    assign diff  = part[W-1:0] - div_i;
    assign rem_o = q_o ? diff : part[W-1:0];

endmodule

// File: rtl/divider_seq.sv
// rtl/divider_seq.sv - sequential restoring divider: 16/8 or dual-lane 8/4, one step per cycle
module divider_seq
    import diff_core_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DVD_W-1:0]    dividend,
    input  logic [LANE_W-1:0]   divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANE_W-1:0]   quot,
    output logic [LANE_W-1:0]   rem,
    output logic [1:0]          ovf
);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic [LANE_W-1:0]   dsr_q, dsr_d;
    logic [LANE_W-1:0]   dvd_q, dvd_d;
    logic [LANE_W-1:0]   rem_q, rem_d;
    logic [1:0]          ovf_q, ovf_d;

    logic [LANE_W-1:0]   step_r8;
    logic                step_q8;
    logic [SUB_W-1:0]    step_rh, step_rl;
    logic                step_qh, step_ql;

    logic                acc_ovf_full, acc_ovf_hi, acc_ovf_lo;

    // dvd_q holds the not-yet-consumed dividend bits; quotient bits enter at
    // the bottom of each lane, so after the last step it holds the quotient.
    div_step #(.W(LANE_W)) u_step_full (
        .rem_i (rem_q),
        .bit_i (dvd_q[LANE_W-1]),
        .div_i (dsr_q),
        .rem_o (step_r8),
        .q_o   (step_q8)
    );

    div_step #(.W(SUB_W)) u_step_hi (
        .rem_i (rem_q[LANE_W-1:SUB_W]),
        .bit_i (dvd_q[LANE_W-1]),
        .div_i (dsr_q[LANE_W-1:SUB_W]),
        .rem_o (step_rh),
        .q_o   (step_qh)
    );

    div_step #(.W(SUB_W)) u_step_lo (
        .rem_i (rem_q[SUB_W-1:0]),
        .bit_i (dvd_q[SUB_W-1]),
        .div_i (dsr_q[SUB_W-1:0]),
        .rem_o (step_rl),
        .q_o   (step_ql)
    );

    // A quotient only fits when the upper half of the dividend is below the divisor.
    assign acc_ovf_full = (divisor == '0)
                       || (dividend[DVD_W-1:LANE_W] >= divisor);
    assign acc_ovf_hi   = (divisor[LANE_W-1:SUB_W] == '0)
                       || (dividend[DVD_W-1:DVD_W-SUB_W] >= divisor[LANE_W-1:SUB_W]);
    assign acc_ovf_lo   = (divisor[SUB_W-1:0] == '0)
                       || (dividend[LANE_W-1:SUB_W] >= divisor[SUB_W-1:0]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dsr_d   = dsr_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_BUSY;
                    mode_d  = mode;
                    dsr_d   = divisor;
                    if (!mode) begin
                        cnt_d = ITER_FULL;
                        ovf_d = {1'b0, acc_ovf_full};
                        rem_d = acc_ovf_full ? '0 : dividend[DVD_W-1:LANE_W];
                        dvd_d = acc_ovf_full ? '1 : dividend[LANE_W-1:0];
                    end else begin
                        cnt_d = ITER_DUAL;
                        ovf_d = {acc_ovf_hi, acc_ovf_lo};
                        rem_d = {acc_ovf_hi ? {SUB_W{1'b0}} : dividend[DVD_W-1:DVD_W-SUB_W],
                                 acc_ovf_lo ? {SUB_W{1'b0}} : dividend[LANE_W-1:SUB_W]};
                        dvd_d = {acc_ovf_hi ? {SUB_W{1'b1}} : dividend[DVD_W-SUB_W-1:LANE_W],
                                 acc_ovf_lo ? {SUB_W{1'b1}} : dividend[SUB_W-1:0]};
                    end
                end
            end

            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
                // Overflowed lanes keep their preloaded all-ones quotient and zero remainder.
                if (!mode_q) begin
                    if (!ovf_q[0]) begin
                        rem_d = step_r8;
                        dvd_d = {dvd_q[LANE_W-2:0], step_q8};
                    end
                end else begin
                    if (!ovf_q[1]) begin
                        rem_d[LANE_W-1:SUB_W] = step_rh;
                        dvd_d[LANE_W-1:SUB_W] = {dvd_q[LANE_W-2:SUB_W], step_qh};
                    end
                    if (!ovf_q[0]) begin
                        rem_d[SUB_W-1:0] = step_rl;
                        dvd_d[SUB_W-1:0] = {dvd_q[SUB_W-2:0], step_ql};
                    end
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            dsr_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dsr_q   <= dsr_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign quot      = dvd_q;
    assign rem       = rem_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_divider_seq.sv
// tb/tb_divider_seq.sv - directed self-checking bench for divider_seq
module tb_divider_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic [1:0]  ovf;

    int total = 0;
    int bad   = 0;

    divider_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic m, input logic [15:0] a,
                           input logic [7:0] b, input int lat_exp, input logic [7:0] eq,
                           input logic [7:0] er, input logic [1:0] eo, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, "/in_ready"}, in_ready, 1);
        mode = m; dividend = a; divisor = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; mode = ~m; dividend = ~a; divisor = ~b;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/latency"}, lat, lat_exp);
        chk({tag, "/quot"}, quot, eq);
        chk({tag, "/rem"}, rem, er);
        chk({tag, "/ovf"}, ovf, eo);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; dividend = 16'h0101; divisor = 8'h01;
            chk({tag, "/hold_valid"}, out_valid, 1);
            chk({tag, "/hold_in_ready"}, in_ready, 0);
            chk({tag, "/hold_result"}, {quot, rem, ovf}, {eq, er, eo});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "/consumed"}, out_valid, 0);
        chk({tag, "/ready_again"}, in_ready, 1);
    endtask

    initial begin
        bit seen;
        #2 rst_n = 1'b0;
        #1;
        chk("reset/in_ready", in_ready, 1);
        chk("reset/out_valid", out_valid, 0);
        chk("reset/outputs", {quot, rem, ovf}, 18'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_req("m0_1000_10", 1'b0, 16'd1000, 8'd10, 8, 8'd100, 8'd0, 2'b00, 0);
        run_req("m1_642D_97", 1'b1, 16'h642D, 8'h97, 4, 8'hB6, 8'h13, 2'b00, 0);
        run_req("m0_div0", 1'b0, 16'h1234, 8'h00, 8, 8'hFF, 8'h00, 2'b01, 0);
        run_req("m0_0A00_05", 1'b0, 16'h0A00, 8'h05, 8, 8'hFF, 8'h00, 2'b01, 0);
        run_req("m1_lo_ovf", 1'b1, 16'h642D, 8'h90, 4, 8'hBF, 8'h10, 2'b01, 0);
        run_req("m1_hi_ovf", 1'b1, 16'hA512, 8'h53, 4, 8'hF6, 8'h00, 2'b10, 0);
        run_req("m0_max_q", 1'b0, 16'h09FF, 8'h0A, 8, 8'hFF, 8'h09, 2'b00, 0);
        run_req("m0_backpressure", 1'b0, 16'd5000, 8'd77, 8, 8'h40, 8'h48, 2'b00, 5);

        // Abandon an operation mid-BUSY with an asynchronous reset.
        @(negedge clk);
        mode = 1'b0; dividend = 16'd1000; divisor = 8'd10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset/out_valid", out_valid, 0);
        chk("midreset/in_ready", in_ready, 1);
        chk("midreset/quot", quot, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midreset/no_result", seen, 0);
        run_req("after_reset_m1", 1'b1, 16'h3B59, 8'h8C, 4, 8'h77, 8'h35, 2'b00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 No parameters; all widths SHALL come from diff_core_pkg constants (8-bit lane, 4-bit sublane).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 mode  input  1  0: 16/8 divide; 1: dual-lane (two 8/4 divides), sampled at accept.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 dividend  input  16  mode 0: full dividend; mode 1: [15:8] high lane, [7:0] low lane.
REQ-008 divisor  input  8  mode 0: full divisor; mode 1: [7:4] high lane, [3:0] low lane.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 quot  output  8  quotient; mode 1: {high-lane q, low-lane q}.
REQ-012 rem  output  8  remainder; mode 1: {high-lane r, low-lane r}.
REQ-013 ovf  output  2  overflow/divide-by-zero flags; mode 0: {0, flag}; mode 1: {high-lane flag, low-lane flag}.

Function
REQ-014 Block SHALL be an inverse companion to the dual-mode multiplier: for non-overflow inputs, quot*divisor+rem == dividend, per lane in mode 1.
REQ-015 FSM states SHALL be IDLE, BUSY, DONE; reset state IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready.
REQ-017 On accept, mode/dividend/divisor SHALL be captured; later input changes are ignored until the next accept.
REQ-018 IDLE -> BUSY on accept; iteration counter loads 8 (mode 0) or 4 (mode 1).
REQ-019 BUSY SHALL perform one restoring shift-subtract step per cycle per lane (one 8-bit lane in mode 0, two independent 4-bit lanes in mode 1).
REQ-020 BUSY -> DONE after the final step; out_valid SHALL assert exactly 8 (mode 0) / 4 (mode 1) cycles after the accept edge.
REQ-021 DONE: out_valid=1; quot/rem/ovf SHALL be held stable until out_ready=1; DONE -> IDLE on out_valid && out_ready.
REQ-022 No overlap: in_ready SHALL be 0 in BUSY and DONE, so a new request is accepted at earliest the cycle after the handshake.
REQ-023 Overflow mode 0: divisor==0 or dividend[15:8] >= divisor -> ovf[0]=1, quot=8'hFF, rem=8'h00.
REQ-024 Overflow mode 1, per lane: divisor nibble==0 or dividend lane upper nibble >= divisor nibble -> that lane's ovf bit=1, q nibble=4'hF, r nibble=4'h0; the other lane is unaffected.
REQ-025 Overflow SHALL be evaluated at accept; latency is unchanged by overflow.
REQ-026 Partial remainder SHALL be one bit wider than its divisor (9 bits mode 0, 5 bits per lane mode 1) so that no compare is lost.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, counter=0, out_valid=0, quot=0, rem=0, ovf=0; in_ready=1 while in reset.
REQ-028 Reset during BUSY or DONE SHALL abandon the operation with no result emitted after release.

Structure
REQ-029 diff_core_pkg SHALL hold the FSM state enum typedef, the lane widths and the iteration counts (8, 4).
REQ-030 One sub-module, div_step (parameterised width, one combinational restoring step: shift in a dividend bit, trial-subtract, produce q bit and next remainder), SHALL be instantiated for the 8-bit lane and for each 4-bit lane.

Verification
REQ-031 Mode 0, dividend 16'd1000, divisor 8'd10 -> quot 8'd100, rem 8'd0, ovf 2'b00, out_valid 8 cycles after accept.
REQ-032 Mode 1, dividend 16'h642D, divisor 8'h97 -> quot 8'hB6, rem 8'h13, ovf 2'b00, out_valid 4 cycles after accept.
REQ-033 Mode 0, divisor 8'h00, any dividend -> quot 8'hFF, rem 8'h00, ovf 2'b01; dividend 16'h0A00, divisor 8'h05 -> same overflow response.
REQ-034 Mode 1, dividend 16'h642D, divisor 8'h90 -> low lane ovf: quot 8'hBF, rem 8'h10, ovf 2'b01.
REQ-035 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; result consumed on the first out_ready=1 cycle.
REQ-036 rst_n pulsed low mid-BUSY -> out_valid=0, in_ready=1 immediately; the next request completes correctly.
